// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: sequencer for a 4:1 bit mux stage.
// Walks the select lines through the enabled channels in ascending order. On
// each channel it holds the select for a programmable settle time, then
// samples the returned bit into a per-channel snapshot. Every sample and every
// completed sweep is reported with a one-cycle pulse. Sweeps can be one-shot
// or continuous.
// Optional feature macro: SCAN_CHANGE_DETECT_EN. When defined, each sweep_done
// is accompanied by a 'changed' flag that compares the new snapshot with the
// snapshot of the previous completed sweep.
module mux_sel_scanner #(
  parameter int NCH     = 4,
  parameter int DWELL_W = 4,
  localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               continuous,
  input  logic [NCH-1:0]     chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mux_out,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               sample_valid,
  output logic [SEL_W-1:0]   sample_chan,
  output logic               sample_bit,
  output logic [NCH-1:0]     snapshot,
  output logic               sweep_done,
  output logic               changed
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               sample_valid_q, sample_valid_d;
  logic [SEL_W-1:0]   sample_chan_q, sample_chan_d;
  logic               sample_bit_q, sample_bit_d;
  logic [NCH-1:0]     snapshot_q, snapshot_d;
  logic               sweep_done_q, sweep_done_d;
`ifdef SCAN_CHANGE_DETECT_EN
  logic               changed_q, changed_d;
  logic [NCH-1:0]     prev_snap_q, prev_snap_d;
`endif

  // Channels of the latched mask that lie strictly above the current select.
  logic [NCH-1:0] above_mask;

  // Index of the lowest set bit; callers only use it on non-zero masks.
  function automatic logic [SEL_W-1:0] lowest_bit(input logic [NCH-1:0] m);
    lowest_bit = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = SEL_W'(i);
    end
  endfunction

  // Build the "higher enabled channel" mask used to pick the next select.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_above
      assign above_mask[gi] = mask_q[gi] & (sel_q < SEL_W'(gi));
    end
  endgenerate

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    dwell_d        = dwell_q;
    busy_d         = busy_q;
    sample_valid_d = 1'b0;
    sample_chan_d  = sample_chan_q;
    sample_bit_d   = sample_bit_q;
    snapshot_d     = snapshot_q;
    sweep_done_d   = 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
    changed_d      = 1'b0;
    prev_snap_d    = prev_snap_q;
`endif

    case (state_q)
      IDLE: begin
        // A request with an empty mask has nothing to visit and is dropped.
        if (start && ena && (chan_mask != '0)) begin
          mask_d  = chan_mask;
          dwell_d = dwell;
          sel_d   = lowest_bit(chan_mask);
          cnt_d   = dwell;
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (!ena) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      SAMPLE: begin
        if (!ena) begin
          // Abort without reporting the sample being taken.
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          snapshot_d[sel_q] = mux_out;
          sample_bit_d      = mux_out;
          sample_chan_d     = sel_q;
          sample_valid_d    = 1'b1;
          if (above_mask != '0) begin
            sel_d   = lowest_bit(above_mask);
            cnt_d   = dwell_q;
            state_d = SETTLE;
          end else begin
            sweep_done_d = 1'b1;
`ifdef SCAN_CHANGE_DETECT_EN
            changed_d    = (snapshot_d != prev_snap_q);
            prev_snap_d  = snapshot_d;
`endif
            // Wrap picks up the live mask and dwell, so reprogramming lands here.
            if (continuous && (chan_mask != '0)) begin
              mask_d  = chan_mask;
              dwell_d = dwell;
              sel_d   = lowest_bit(chan_mask);
              cnt_d   = dwell;
              state_d = SETTLE;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset takes effect without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      cnt_q          <= '0;
      mask_q         <= '0;
      dwell_q        <= '0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_chan_q  <= '0;
      sample_bit_q   <= 1'b0;
      snapshot_q     <= '0;
      sweep_done_q   <= 1'b0;
`ifdef SCAN_CHANGE_DETECT_EN
      changed_q      <= 1'b0;
      prev_snap_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      dwell_q        <= dwell_d;
      busy_q         <= busy_d;
      sample_valid_q <= sample_valid_d;
      sample_chan_q  <= sample_chan_d;
      sample_bit_q   <= sample_bit_d;
      snapshot_q     <= snapshot_d;
      sweep_done_q   <= sweep_done_d;
`ifdef SCAN_CHANGE_DETECT_EN
      changed_q      <= changed_d;
      prev_snap_q    <= prev_snap_d;
`endif
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign sample_valid = sample_valid_q;
  assign sample_chan  = sample_chan_q;
  assign sample_bit   = sample_bit_q;
  assign snapshot     = snapshot_q;
  assign sweep_done   = sweep_done_q;
`ifdef SCAN_CHANGE_DETECT_EN
  assign changed      = changed_q;
`else
  assign changed      = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Testbench for mux_sel_scanner (NCH=4, DWELL_W=4).
// A table of one-shot sweeps is applied from reset, followed by hand-written
// sequences for empty mask, enable abort, continuous mode and async reset.
module tb_mux_sel_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] chan_mask = 4'h0;
  logic [3:0] dwell = 4'h0;
  logic [3:0] chan_val = 4'h0;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic       sample_valid;
  logic [1:0] sample_chan;
  logic       sample_bit;
  logic [3:0] snapshot;
  logic       sweep_done;
  logic       changed;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] dwell;
    logic [3:0] vals;         // bit i = value the mux returns on channel i
    logic [3:0] exp_snap;     // snapshot after one sweep from reset
    int         exp_samples;  // sample_valid pulses in the sweep
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  // Mux stage model: returns the bit of the currently selected channel.
  always_comb mux_out = chan_val[sel];

  mux_sel_scanner #(.NCH(4), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .continuous(continuous),
    .chan_mask(chan_mask), .dwell(dwell), .mux_out(mux_out), .sel(sel),
    .busy(busy), .sample_valid(sample_valid), .sample_chan(sample_chan),
    .sample_bit(sample_bit), .snapshot(snapshot), .sweep_done(sweep_done),
    .changed(changed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int next_bit(input logic [3:0] m, input int after);
    for (int i = after + 1; i < 4; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int highest_bit(input logic [3:0] m);
    for (int i = 3; i >= 0; i--) if (m[i]) return i;
    return 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    int cyc, nsamp, last, last_cyc, exp_ch;
    bit done;
    do_reset();
    chan_val = v.vals;
    ena = 1'b1;
    @(negedge clk);
    chan_mask = v.mask;
    dwell = v.dwell;
    start = 1'b1;
    cyc = 0; nsamp = 0; last = -1; last_cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // Scramble mask/dwell mid-sweep: the latched copies must be used.
        start = 1'b0;
        chan_mask = ~v.mask;
        dwell = 4'hf;
        check("busy_at_start", {31'd0, busy}, 32'd1);
        check("sel_first", {30'd0, sel}, next_bit(v.mask, -1));
      end
      if (sample_valid) begin
        exp_ch = next_bit(v.mask, last);
        check("sample_chan", {30'd0, sample_chan}, exp_ch);
        check("sample_bit", {31'd0, sample_bit}, {31'd0, v.vals[exp_ch[1:0]]});
        if (nsamp == 0) check("first_latency", cyc - 1, v.dwell + 2);
        else            check("sample_gap", cyc - last_cyc, v.dwell + 2);
        nsamp++;
        last = exp_ch;
        last_cyc = cyc;
      end
      if (sweep_done) begin
        check("done_with_sample", {31'd0, sample_valid}, 32'd1);
        check("sample_count", nsamp, v.exp_samples);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        done = 1'b1;
      end
    end
    if (!done) check("sweep_timeout", 32'd0, 32'd1);
    check("snapshot", {28'd0, snapshot}, {28'd0, v.exp_snap});
    @(negedge clk);
    check("idle_quiet", {29'd0, sample_valid, sweep_done, busy}, 32'd0);
    check("sel_hold", {30'd0, sel}, highest_bit(v.mask));
    $display("vector %0d: mask=%b dwell=%0d samples=%0d snapshot=%b", idx, v.mask, v.dwell, nsamp, snapshot);
    chan_mask = 4'h0;
  endtask

  initial begin
    int   nd;
    logic [2:0] chg_bits, exp_chg;
    bit   quiet_bad;

    vecs[0] = '{mask: 4'b1111, dwell: 4'd2, vals: 4'b1101, exp_snap: 4'b1101, exp_samples: 4};
    vecs[1] = '{mask: 4'b1010, dwell: 4'd0, vals: 4'b1111, exp_snap: 4'b1010, exp_samples: 2};
    vecs[2] = '{mask: 4'b0001, dwell: 4'd5, vals: 4'b0001, exp_snap: 4'b0001, exp_samples: 1};
    vecs[3] = '{mask: 4'b0110, dwell: 4'd1, vals: 4'b0100, exp_snap: 4'b0100, exp_samples: 2};
    vecs[4] = '{mask: 4'b1000, dwell: 4'd0, vals: 4'b0111, exp_snap: 4'b0000, exp_samples: 1};
    vecs[5] = '{mask: 4'b1001, dwell: 4'd3, vals: 4'b1111, exp_snap: 4'b1001, exp_samples: 2};

    // Reset state, applied asynchronously between clock edges.
    #3 rst_n = 1'b0;
    #1;
    check("reset_outputs", {22'd0, sel, busy, sample_valid, sample_chan, sample_bit, snapshot, sweep_done, changed}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vector(i, vecs[i]);

    // Async reset mid-SETTLE, following a sweep that left non-zero outputs.
    @(negedge clk);
    chan_mask = 4'b1110; dwell = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {22'd0, sel, busy, sample_valid, sample_chan, sample_bit, snapshot, sweep_done, changed}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || sample_valid || sweep_done || sel != 2'd0) quiet_bad = 1'b1;
    end
    check("idle_after_release", {31'd0, quiet_bad}, 32'd0);
    $display("seq reset: mid-settle reset, quiet=%0b", !quiet_bad);

    // Start with an empty mask is ignored.
    do_reset();
    ena = 1'b1; chan_mask = 4'b0000; dwell = 4'd1; start = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy || sample_valid || sweep_done || sel != 2'd0) quiet_bad = 1'b1;
    end
    start = 1'b0;
    check("empty_mask_ignored", {31'd0, quiet_bad}, 32'd0);
    $display("seq empty mask: quiet=%0b", !quiet_bad);

    // Enable dropped while settling on channel 1.
    do_reset();
    ena = 1'b1; chan_val = 4'b1111;
    @(negedge clk);
    chan_mask = 4'b1111; dwell = 4'd3; start = 1'b1;
    quiet_bad = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (cyc == 6) begin
        check("abort_first_sample", {29'd0, sample_valid, sample_chan}, {29'd0, 3'b100});
      end
      if (cyc == 7) begin
        check("abort_settle_chan1", {30'd0, sel}, 32'd1);
        ena = 1'b0;
      end
      if (cyc != 6 && (sample_valid || sweep_done)) quiet_bad = 1'b1;
    end
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_snapshot", {28'd0, snapshot}, 32'h1);
    check("abort_sel_hold", {30'd0, sel}, 32'd1);
    ena = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy || sample_valid || sweep_done) quiet_bad = 1'b1;
    end
    check("abort_no_pulses", {31'd0, quiet_bad}, 32'd0);
    $display("seq ena abort: busy=%0b snapshot=%b", busy, snapshot);

    // Continuous single-channel sweeps; input flips after sweep 1,
    // continuous drops during sweep 3.
    do_reset();
    ena = 1'b1; chan_val = 4'b0000; continuous = 1'b1;
    @(negedge clk);
    chan_mask = 4'b0100; dwell = 4'd1; start = 1'b1;
    nd = 0; chg_bits = 3'b000; quiet_bad = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (sweep_done) begin
        if (!sample_valid) quiet_bad = 1'b1;
        if (nd < 3) chg_bits[nd] = changed;
        nd++;
        if (nd == 1) chan_val[2] = 1'b1;
        if (nd == 2) continuous = 1'b0;
      end else if (changed) begin
        quiet_bad = 1'b1;
      end
    end
`ifdef SCAN_CHANGE_DETECT_EN
    exp_chg = 3'b010;
`else
    exp_chg = 3'b000;
`endif
    check("cont_sweep_count", nd, 32'd3);
    check("cont_changed", {29'd0, chg_bits}, {29'd0, exp_chg});
    check("cont_pulse_shape", {31'd0, quiet_bad}, 32'd0);
    check("cont_idle", {31'd0, busy}, 32'd0);
    check("cont_snapshot", {28'd0, snapshot}, 32'h4);
    $display("seq continuous: sweeps=%0d changed=%b", nd, chg_bits);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
